// File: rtl/control_unit.sv
// rtl/control_unit.sv - four-phase fetch/decode/execute/writeback sequencer driving an external ALU
// Holds R0..R3, IR, PC and the carry flag; one instruction per FETCH-DECODE-EXECUTE-WRITEBACK pass.
module control_unit #(
  parameter int SIZE = 8,
  parameter int PC_W = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            run,
  input  logic            instr_valid,
  input  logic [SIZE+7:0] instr_data,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic            alu_CE,
  output logic [2:0]      alu_OP_CODE,
  output logic [SIZE-1:0] alu_left,
  output logic [SIZE-1:0] alu_right,
  output logic            alu_carry_in,
  input  logic [SIZE-1:0] alu_op_out,
  input  logic            alu_carry_out,
  output logic [SIZE-1:0] acc_out,
  output logic            carry_flag
);

  localparam logic [1:0] FETCH     = 2'd0;
  localparam logic [1:0] DECODE    = 2'd1;
  localparam logic [1:0] EXECUTE   = 2'd2;
  localparam logic [1:0] WRITEBACK = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_ST  = 3'd7;

  logic [1:0]      state;
  logic [SIZE+7:0] ir;
  logic [SIZE-1:0] regs [4];
  logic            c;
  logic [SIZE-1:0] res_q;
  logic            carry_q;

  logic [2:0]      opcode;
  logic [1:0]      rs;
  logic            use_carry;
  logic            imm_sel;
  logic [SIZE-1:0] imm;
  logic            unused_reserved;

  assign opcode          = ir[SIZE+7:SIZE+5];
  assign rs              = ir[SIZE+4:SIZE+3];
  assign use_carry       = ir[SIZE+2];
  assign imm_sel         = ir[SIZE+1];
  assign imm             = ir[SIZE-1:0];
  assign unused_reserved = ir[SIZE];

  // Ready is masked by RST so nothing looks accepted while the block is held in reset.
  assign instr_ready = (state == FETCH) && run && !RST;
  assign alu_CE      = (state == EXECUTE);
  assign acc_out     = regs[0];
  assign carry_flag  = c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= FETCH;
      ir           <= '0;
      pc           <= '0;
      c            <= 1'b0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      alu_OP_CODE  <= '0;
      alu_left     <= '0;
      alu_right    <= '0;
      alu_carry_in <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (instr_valid && run) begin
            ir    <= instr_data;
            pc    <= pc + PC_W'(1);
            state <= DECODE;
          end
        end
        DECODE: begin
          alu_left     <= regs[0];
          alu_right    <= imm_sel ? imm : regs[rs];
          alu_carry_in <= use_carry & c;
          alu_OP_CODE  <= opcode;
          state        <= EXECUTE;
        end
        EXECUTE: begin
          res_q   <= alu_op_out;
          carry_q <= alu_carry_out;
          state   <= WRITEBACK;
        end
        WRITEBACK: begin
          // ST targets R[rs]; everything else accumulates into R0.
          if (opcode == OP_ST) regs[rs] <= res_q;
          else                 regs[0]  <= res_q;
          if (opcode == OP_ADD || opcode == OP_SUB) c <= carry_q;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit with an ALU model and instruction-level scoreboard
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic        instr_ready;
  logic [7:0]  pc;
  logic        alu_CE;
  logic [2:0]  alu_OP_CODE;
  logic [7:0]  alu_left;
  logic [7:0]  alu_right;
  logic        alu_carry_in;
  logic [7:0]  alu_op_out;
  logic        alu_carry_out;
  logic [7:0]  acc_out;
  logic        carry_flag;

  always #5 clk = ~clk;

  control_unit #(.SIZE(8), .PC_W(8)) dut (
    .CLK(clk), .RST(rst), .run(run), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_ready(instr_ready), .pc(pc), .alu_CE(alu_CE), .alu_OP_CODE(alu_OP_CODE),
    .alu_left(alu_left), .alu_right(alu_right), .alu_carry_in(alu_carry_in),
    .alu_op_out(alu_op_out), .alu_carry_out(alu_carry_out),
    .acc_out(acc_out), .carry_flag(carry_flag)
  );

  // ALU behaviour: {carry,result}; LD passes right, ST passes left, NOT inverts left.
  function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] l, input logic [7:0] r,
                                        input logic ci);
    case (op)
      3'd0:    return {1'b0, l} + {1'b0, r} + {8'd0, ci};
      3'd1:    return {1'b0, l} - {1'b0, r} + {8'd0, ci};
      3'd2:    return {1'b0, l & r};
      3'd3:    return {1'b0, l | r};
      3'd4:    return {1'b0, l ^ r};
      3'd5:    return {1'b0, ~l};
      3'd6:    return {1'b0, r};
      default: return {1'b0, l};
    endcase
  endfunction

  assign {alu_carry_out, alu_op_out} = alu_fn(alu_OP_CODE, alu_left, alu_right, alu_carry_in);

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rs, input logic uc,
                                     input logic isel, input logic [7:0] imm);
    return {op, rs, uc, isel, 1'b1, imm};
  endfunction

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Instruction-level model: register file, flag, pc and a phase count since acceptance.
  logic [7:0]  m_r [4];
  logic        m_c;
  logic [7:0]  m_pc;
  int          m_ph;
  logic [15:0] m_ir;
  bit          model_on = 1'b0;

  always @(negedge clk) begin
    if (model_on) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_c = 1'b0; m_pc = 8'h00; m_ph = 0; m_ir = 16'h0000;
      end
      chk("ready", {31'd0, instr_ready}, {31'd0, (m_ph == 0) && run && !rst});
      chk("alu_ce", {31'd0, alu_CE}, {31'd0, m_ph == 2});
      chk("pc", {24'd0, pc}, {24'd0, m_pc});
      chk("acc", {24'd0, acc_out}, {24'd0, m_r[0]});
      chk("carry", {31'd0, carry_flag}, {31'd0, m_c});
      if (rst)
        chk("alu_regs_reset", {13'd0, alu_OP_CODE, alu_left, alu_right, alu_carry_in}, 32'd0);
      if (m_ph == 2 && !rst) begin
        chk("alu_op", {29'd0, alu_OP_CODE}, {29'd0, m_ir[15:13]});
        chk("alu_left", {24'd0, alu_left}, {24'd0, m_r[0]});
        chk("alu_right", {24'd0, alu_right}, {24'd0, m_ir[9] ? m_ir[7:0] : m_r[m_ir[12:11]]});
        chk("alu_cin", {31'd0, alu_carry_in}, {31'd0, m_ir[10] & m_c});
      end
      if (!rst) begin
        case (m_ph)
          0: if (run && instr_valid) begin
               m_ir = instr_data; m_pc = m_pc + 8'd1; m_ph = 1;
             end
          1: m_ph = 2;
          2: m_ph = 3;
          default: begin
            logic [8:0] res;
            res = alu_fn(m_ir[15:13], m_r[0], m_ir[9] ? m_ir[7:0] : m_r[m_ir[12:11]], m_ir[10] & m_c);
            if (m_ir[15:13] == 3'd7) m_r[m_ir[12:11]] = res[7:0];
            else                     m_r[0]           = res[7:0];
            if (m_ir[15:13] <= 3'd1) m_c = res[8];
            m_ph = 0;
          end
        endcase
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [15:0] w);
    instr_data  = w;
    instr_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_data  = 16'hBEEF;
  endtask

  task automatic issue_wait(input logic [15:0] w);
    issue(w);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string name, input logic [7:0] acc, input logic c);
    chk({name, "_acc"}, {24'd0, acc_out}, {24'd0, acc});
    chk({name, "_c"}, {31'd0, carry_flag}, {31'd0, c});
    chk({name, "_model_acc"}, {24'd0, m_r[0]}, {24'd0, acc});
    chk({name, "_model_c"}, {31'd0, m_c}, {31'd0, c});
  endtask

  initial begin
    int bad_gaps;
    int last;
    rst = 1'b1; run = 1'b1; instr_valid = 1'b0; instr_data = 16'h0000;
    model_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", {24'd0, pc}, 32'd0);
    chk("reset_ready", {31'd0, instr_ready}, 32'd0);
    chk("reset_acc", {24'd0, acc_out}, 32'd0);
    rst = 1'b0;

    issue_wait(mk(3'd6, 2'd0, 1'b0, 1'b1, 8'h7F));
    expect_state("ld7f", 8'h7F, 1'b0);
    issue_wait(mk(3'd0, 2'd0, 1'b0, 1'b1, 8'h01));
    expect_state("add01", 8'h80, 1'b0);
    issue_wait(mk(3'd0, 2'd0, 1'b0, 1'b1, 8'h80));
    expect_state("add80", 8'h00, 1'b1);

    issue_wait(mk(3'd0, 2'd0, 1'b1, 1'b1, 8'h00));
    expect_state("addc", 8'h01, 1'b0);
    issue_wait(mk(3'd0, 2'd0, 1'b0, 1'b1, 8'hFF));
    expect_state("addff", 8'h00, 1'b1);
    issue_wait(mk(3'd2, 2'd0, 1'b0, 1'b1, 8'h0F));
    expect_state("and0f", 8'h00, 1'b1);

    issue_wait(mk(3'd6, 2'd0, 1'b0, 1'b1, 8'h5A));
    issue_wait(mk(3'd7, 2'd2, 1'b0, 1'b0, 8'h00));
    expect_state("st2", 8'h5A, 1'b1);
    issue_wait(mk(3'd6, 2'd0, 1'b0, 1'b1, 8'h00));
    expect_state("ld00", 8'h00, 1'b1);
    issue_wait(mk(3'd6, 2'd2, 1'b0, 1'b0, 8'hAA));
    expect_state("ldr2", 8'h5A, 1'b1);
    issue_wait(mk(3'd4, 2'd2, 1'b0, 1'b0, 8'hAA));
    expect_state("xorr2", 8'h00, 1'b1);

    issue_wait(mk(3'd6, 2'd0, 1'b0, 1'b1, 8'h05));
    issue_wait(mk(3'd1, 2'd0, 1'b0, 1'b1, 8'h03));
    expect_state("sub", 8'h02, 1'b0);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_pc", {24'd0, pc}, 32'd13);
      chk("idle_ready", {31'd0, instr_ready}, 32'd1);
    end
    run = 1'b0; instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("norun_pc", {24'd0, pc}, 32'd13);
      chk("norun_ready", {31'd0, instr_ready}, 32'd0);
      chk("norun_ce", {31'd0, alu_CE}, 32'd0);
    end

    run = 1'b1;
    issue(mk(3'd6, 2'd0, 1'b0, 1'b1, 8'h33));
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_state("runlate", 8'h33, 1'b0);
    chk("runlate_pc", {24'd0, pc}, 32'd14);
    run = 1'b1;
    issue_wait(mk(3'd0, 2'd0, 1'b0, 1'b1, 8'hFF));
    expect_state("add_ff2", 8'h32, 1'b1);

    issue(mk(3'd0, 2'd0, 1'b0, 1'b1, 8'h01));
    @(posedge clk); #1;
    chk("exec_ce", {31'd0, alu_CE}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_acc", {24'd0, acc_out}, 32'd0);
    chk("abort_c", {31'd0, carry_flag}, 32'd0);
    chk("abort_pc", {24'd0, pc}, 32'd0);
    chk("abort_ce", {31'd0, alu_CE}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    bad_gaps = 0;
    last = 0;
    instr_data  = mk(3'd0, 2'd0, 1'b0, 1'b1, 8'h01);
    instr_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_ready();
      @(posedge clk); #1;
      if (i > 0 && cyc - last != 4) bad_gaps++;
      last = cyc;
      if (i == 255) instr_valid = 1'b0;
    end
    chk("wrap_gaps", bad_gaps, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_pc", {24'd0, pc}, 32'd0);
    expect_state("wrap", 8'h00, 1'b1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
